port_bind_arbiter: RTL and testbench

- Shares a table of listening TCP port bindings between NREQ requesters, such as the main server listener, the config interface, and the experimental HTTP module.
- Arbitrates bind and release requests round-robin.
- Scans the table sequentially for collisions and free slots.
- Returns OK / TAKEN / FULL / INVALID, so software can re-prompt for another port, as for an unavailable config port.

---
 rtl/port_bind_arbiter.sv | 271 +++++++++++++++++++++++++++
 tb/tb_port_bind_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/port_bind_arbiter.sv
// port_bind_arbiter
//   Shares a table of listening TCP port bindings between NREQ requesters.
//   Bind/release requests are arbitrated round-robin; each accepted request
//   walks the whole table (fixed latency) looking for a collision, a free slot
//   or the entry to release, then commits the table write and answers with
//   OK / TAKEN / FULL / INVALID(NOTFOUND).
//
// Optional build macro:
//   PORT_PRIV_CHECK_EN - adds priv_mask; binds below port 1024 from an
//                        unprivileged requester are rejected as INVALID.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   req_valid    per-requester request strobe, held until req_ready
//   req_op       per-requester op: 0 = bind, 1 = release
//   req_port     per-requester port number, requester i at [i*PW +: PW]
//   priv_mask    (PORT_PRIV_CHECK_EN only) per-requester privilege bit
//   req_ready    one-hot accept pulse
//   resp_valid   one-hot response pulse to the accepted requester
//   resp_code    0 OK, 1 TAKEN, 2 FULL, 3 INVALID/NOTFOUND (with resp_valid)
//   busy         high from accept through the response cycle
//   bound_count  number of valid table entries
module port_bind_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NSLOT = 8,
  parameter int unsigned PW    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_op,
  input  logic [NREQ*PW-1:0]         req_port,
`ifdef PORT_PRIV_CHECK_EN
  input  logic [NREQ-1:0]            priv_mask,
`endif
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            resp_valid,
  output logic [1:0]                 resp_code,
  output logic                       busy,
  output logic [$clog2(NSLOT+1)-1:0] bound_count
);

  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned IW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int unsigned CW = $clog2(NSLOT + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StDone = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  localparam logic [1:0] CodeOk      = 2'd0;
  localparam logic [1:0] CodeTaken   = 2'd1;
  localparam logic [1:0] CodeFull    = 2'd2;
  localparam logic [1:0] CodeInvalid = 2'd3;

  // Binding table
  logic          tbl_valid_q [NSLOT];
  logic [PW-1:0] tbl_port_q  [NSLOT];
  logic [OW-1:0] tbl_owner_q [NSLOT];

  logic          tbl_we;
  logic [IW-1:0] tbl_wr_idx;
  logic          tbl_wr_valid;

  // Control state
  logic [1:0]    state_q, state_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic          op_q, op_d;
  logic [PW-1:0] port_q, port_d;
  logic [OW-1:0] own_q, own_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          match_q, match_d;
  logic          free_found_q, free_found_d;
  logic [IW-1:0] free_idx_q, free_idx_d;
  logic [IW-1:0] hit_idx_q, hit_idx_d;
  logic          inv_q, inv_d;
  logic [1:0]    code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Round-robin pick: first set req_valid at or above ptr_q, wrapping.
  logic          win_found;
  logic [OW-1:0] win_idx;
  logic [PW-1:0] win_port;
  logic          win_op;
  logic          accept;
  logic          slot_match;
  logic          priv_ok;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_port  = '0;
    win_op    = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned cand;
      cand = (int'(ptr_q) + k) % NREQ;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = OW'(cand);
        win_port  = req_port[cand*PW +: PW];
        win_op    = req_op[cand];
      end
    end
  end

  assign accept = (state_q == StIdle) && win_found && !rst;

`ifdef PORT_PRIV_CHECK_EN
  assign priv_ok = (win_port >= PW'(1024)) || priv_mask[win_idx];
`else
  assign priv_ok = 1'b1;
`endif

  // Release also requires the owner to match; bind only cares about the port.
  assign slot_match = tbl_valid_q[idx_q] && (tbl_port_q[idx_q] == port_q) &&
                      (!op_q || (tbl_owner_q[idx_q] == own_q));

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    op_d         = op_q;
    port_d       = port_q;
    own_d        = own_q;
    idx_d        = idx_q;
    match_d      = match_q;
    free_found_d = free_found_q;
    free_idx_d   = free_idx_q;
    hit_idx_d    = hit_idx_q;
    inv_d        = inv_q;
    code_d       = code_q;
    cnt_d        = cnt_q;
    tbl_we       = 1'b0;
    tbl_wr_idx   = '0;
    tbl_wr_valid = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          op_d         = win_op;
          port_d       = win_port;
          own_d        = win_idx;
          ptr_d        = OW'((int'(win_idx) + 1) % NREQ);
          match_d      = 1'b0;
          free_found_d = 1'b0;
          idx_d        = '0;
          code_d       = CodeOk;
          if (!win_op && ((win_port == '0) || !priv_ok)) begin
            inv_d   = 1'b1;
            code_d  = CodeInvalid;
            state_d = StDone;
          end else begin
            inv_d   = 1'b0;
            state_d = StScan;
          end
        end
      end
      StScan: begin
        if (slot_match) begin
          match_d   = 1'b1;
          hit_idx_d = idx_q;
        end
        if (!op_q && !tbl_valid_q[idx_q] && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        // Always walk the full table so latency does not depend on contents.
        if (idx_q == IW'(NSLOT - 1)) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      StDone: begin
        if (!inv_q) begin
          if (!op_q) begin
            if (match_q) begin
              code_d = CodeTaken;
            end else if (!free_found_q) begin
              code_d = CodeFull;
            end else begin
              code_d       = CodeOk;
              tbl_we       = 1'b1;
              tbl_wr_idx   = free_idx_q;
              tbl_wr_valid = 1'b1;
              cnt_d        = cnt_q + CW'(1);
            end
          end else begin
            if (match_q) begin
              code_d       = CodeOk;
              tbl_we       = 1'b1;
              tbl_wr_idx   = hit_idx_q;
              tbl_wr_valid = 1'b0;
              cnt_d        = cnt_q - CW'(1);
            end else begin
              code_d = CodeInvalid;
            end
          end
        end
        state_d = StResp;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      op_q         <= 1'b0;
      port_q       <= '0;
      own_q        <= '0;
      idx_q        <= '0;
      match_q      <= 1'b0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      hit_idx_q    <= '0;
      inv_q        <= 1'b0;
      code_q       <= CodeOk;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      op_q         <= op_d;
      port_q       <= port_d;
      own_q        <= own_d;
      idx_q        <= idx_d;
      match_q      <= match_d;
      free_found_q <= free_found_d;
      free_idx_q   <= free_idx_d;
      hit_idx_q    <= hit_idx_d;
      inv_q        <= inv_d;
      code_q       <= code_d;
      cnt_q        <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < NSLOT; s++) begin
        tbl_valid_q[s] <= 1'b0;
        tbl_port_q[s]  <= '0;
        tbl_owner_q[s] <= '0;
      end
    end else if (tbl_we) begin
      // A release clears the whole entry, not just the valid bit.
      tbl_valid_q[tbl_wr_idx] <= tbl_wr_valid;
      tbl_port_q[tbl_wr_idx]  <= tbl_wr_valid ? port_q : '0;
      tbl_owner_q[tbl_wr_idx] <= tbl_wr_valid ? own_q : '0;
    end
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_code  = 2'd0;
    if (accept) begin
      req_ready[win_idx] = 1'b1;
    end
    if (state_q == StResp) begin
      resp_valid[own_q] = 1'b1;
      resp_code         = code_q;
    end
  end

  assign busy        = (state_q != StIdle) || accept;
  assign bound_count = cnt_q;

endmodule

// File: tb/tb_port_bind_arbiter.sv
module tb_port_bind_arbiter;

  localparam int NREQ  = 4;
  localparam int NSLOT = 8;
  localparam int PW    = 16;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_op;
  logic [NREQ*PW-1:0]   req_port;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      resp_valid;
  logic [1:0]           resp_code;
  logic                 busy;
  logic [3:0]           bound_count;

  port_bind_arbiter #(.NREQ(NREQ), .NSLOT(NSLOT), .PW(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_port    (req_port),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_code   (resp_code),
    .busy        (busy),
    .bound_count (bound_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct {
    int r;
    bit op;
    int port;
    int exp_code;
    int exp_lat;
    int exp_cnt;
  } vec_t;

  vec_t vecs[$];

  // Issue one request from requester r; report accept->response latency,
  // response code and the response one-hot. -1 marks a timeout.
  task automatic do_op(input int r, input bit op, input int port,
                       output int lat, output int code, output int rv);
    int  t_acc;
    bit  got;
    logic [PW-1:0] p;
    p = port[PW-1:0];
    lat = -1; code = -1; rv = -1; t_acc = 0;
    req_valid[r] = 1'b1;
    req_op[r]    = op;
    req_port[r*PW +: PW] = p;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        got = 1'b1;
        t_acc = cyc;
      end
    end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    if (!got) return;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (|resp_valid) begin
        got  = 1'b1;
        lat  = cyc - t_acc;
        code = int'(resp_code);
        rv   = int'(resp_valid);
      end
    end
  endtask

  initial begin
    int lat, code, rv, n_acc, n_resp;
    int order[4];
    logic [NREQ-1:0] rdy;
    int fill_ports[8];

    fill_ports = '{22202, 8080, 443, 8443, 3000, 5000, 6000, 7000};

    // Directed vectors: {requester, op, port, code, latency, bound_count}
    vecs.push_back('{0, 1'b0, 80,   0, 10, 1});  // first bind OK
    vecs.push_back('{1, 1'b0, 80,   1, 10, 1});  // same port -> TAKEN
    vecs.push_back('{2, 1'b1, 80,   3, 10, 1});  // non-owner release -> NOTFOUND
    vecs.push_back('{0, 1'b1, 80,   0, 10, 0});  // owner release OK
    vecs.push_back('{3, 1'b0, 0,    3, 2,  0});  // port 0 -> INVALID fast path
    for (int i = 0; i < 8; i++)
      vecs.push_back('{i % 4, 1'b0, fill_ports[i], 0, 10, i + 1});
    vecs.push_back('{1, 1'b0, 9999, 2, 10, 8});  // table full
    vecs.push_back('{1, 1'b0, 8080, 1, 10, 8});  // collision beats FULL; ptr -> 2

    req_valid = '0;
    req_op    = '0;
    req_port  = '0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset req_ready",   int'(req_ready), 0);
    chk("reset resp_valid",  int'(resp_valid), 0);
    chk("reset resp_code",   int'(resp_code), 0);
    chk("reset busy",        int'(busy), 0);
    chk("reset bound_count", int'(bound_count), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[v]) begin
      do_op(vecs[v].r, vecs[v].op, vecs[v].port, lat, code, rv);
      chk($sformatf("vec%0d code", v), code, vecs[v].exp_code);
      chk($sformatf("vec%0d latency", v), lat, vecs[v].exp_lat);
      chk($sformatf("vec%0d resp_valid", v), rv, 1 << vecs[v].r);
      chk($sformatf("vec%0d bound_count", v), int'(bound_count), vecs[v].exp_cnt);
      @(posedge clk); #1;
    end

    // Round-robin: all four request at once with pointer at 2.
    req_valid = '1;
    req_op    = '0;
    req_port  = '0;
    n_acc = 0;
    for (int i = 0; i < 80 && n_acc < 4; i++) begin
      @(negedge clk);
      if (|req_ready) begin
        rdy = req_ready;
        chk("rr onehot", $countones(rdy), 1);
        for (int k = 0; k < NREQ; k++) if (rdy[k]) order[n_acc] = k;
        n_acc++;
        @(posedge clk); #1;
        req_valid = req_valid & ~rdy;
      end
    end
    chk("rr accepts", n_acc, 4);
    chk("rr order0", order[0], 2);
    chk("rr order1", order[1], 3);
    chk("rr order2", order[2], 0);
    chk("rr order3", order[3], 1);
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of a scan: no response, table emptied.
    req_valid[0] = 1'b1;
    req_op[0]    = 1'b0;
    req_port[0 +: PW] = 16'd1234;
    n_acc = 0;
    for (int i = 0; i < 20 && n_acc == 0; i++) begin
      @(negedge clk);
      if (req_ready[0]) n_acc = 1;
    end
    chk("midscan accept", n_acc, 1);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("midscan busy", int'(busy), 1);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst busy",        int'(busy), 0);
    chk("rst resp_valid",  int'(resp_valid), 0);
    chk("rst req_ready",   int'(req_ready), 0);
    chk("rst resp_code",   int'(resp_code), 0);
    chk("rst bound_count", int'(bound_count), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    n_resp = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (|resp_valid) n_resp++;
    end
    chk("no resp after reset", n_resp, 0);
    @(posedge clk); #1;

    // Table must be empty again: a bind succeeds with count 1.
    do_op(3, 1'b0, 80, lat, code, rv);
    chk("post-reset code", code, 0);
    chk("post-reset latency", lat, 10);
    chk("post-reset resp_valid", rv, 8);
    chk("post-reset bound_count", int'(bound_count), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
